// File: rtl/req_gnt_latency_checker.sv
// Multi-channel request->grant latency monitor: each armed check expects a grant
// inside a [min_lat,max_lat] cycle window latched at arm time.
module req_gnt_latency_checker #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned LW           = 4,
    parameter int unsigned CW           = 16,
    parameter bit          ABORT_ON_DIS = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] enb,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] gnt,
    input  logic [LW-1:0]  min_lat,
    input  logic [LW-1:0]  max_lat,
    input  logic           clr_err,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] pass_pulse,
    output logic [NCH-1:0] fail_pulse,
    output logic [NCH-1:0] err_sticky,
    output logic           cfg_err,
    output logic [CW-1:0]  pass_cnt,
    output logic [CW-1:0]  fail_cnt
);
    localparam int unsigned PW = $clog2(NCH + 1);
    localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CW) - SW'(1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                 state_q [NCH];
    state_t                 state_c [NCH];
    logic [NCH-1:0][LW-1:0] k_q;
    logic [NCH-1:0][LW-1:0] lat_min_q;
    logic [NCH-1:0][LW-1:0] lat_max_q;
    logic [NCH-1:0]         pass_c;
    logic [NCH-1:0]         fail_c;
    logic [NCH-1:0]         arm_c;
    logic [LW-1:0]          eff_min_c;
    logic [PW-1:0]          pass_num_c;
    logic [PW-1:0]          fail_num_c;

    function automatic logic [PW-1:0] popcnt(input logic [NCH-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [PW-1:0] inc);
        logic [SW-1:0] sum;
        sum = SW'(cnt) + SW'(inc);
        return (sum > CNT_MAX) ? {CW{1'b1}} : CW'(sum);
    endfunction

    assign eff_min_c  = (min_lat == '0) ? LW'(1) : min_lat;
    assign pass_num_c = popcnt(pass_c);
    assign fail_num_c = popcnt(fail_c);

    // k_q holds the index of the upcoming edge relative to T0, so it starts at 1.
    always_comb begin
        pass_c = '0;
        fail_c = '0;
        arm_c  = '0;
        for (int i = 0; i < NCH; i++) begin
            state_c[i] = state_q[i];
            if (state_q[i] == WAIT) begin
                if (gnt[i]) begin
                    if (k_q[i] < lat_min_q[i]) fail_c[i] = 1'b1;
                    else                       pass_c[i] = 1'b1;
                end else if (k_q[i] == lat_max_q[i]) begin
                    fail_c[i] = 1'b1;
                end
                if (pass_c[i] || fail_c[i])       state_c[i] = IDLE;
                else if (ABORT_ON_DIS && !enb[i]) state_c[i] = IDLE;
            end
            arm_c[i] = (state_c[i] == IDLE) && enb[i] && req[i] && !cfg_err;
            if (arm_c[i]) state_c[i] = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
            end
            k_q        <= '0;
            lat_min_q  <= '0;
            lat_max_q  <= '0;
            busy       <= '0;
            pass_pulse <= '0;
            fail_pulse <= '0;
            err_sticky <= '0;
            cfg_err    <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_c[i];
                busy[i]    <= (state_c[i] == WAIT);
                if (arm_c[i]) begin
                    k_q[i]       <= LW'(1);
                    lat_min_q[i] <= eff_min_c;
                    lat_max_q[i] <= max_lat;
                end else if (state_q[i] == WAIT) begin
                    k_q[i] <= k_q[i] + LW'(1);
                end
            end
            pass_pulse <= pass_c;
            fail_pulse <= fail_c;
            // A same-edge event survives a clear.
            err_sticky <= (clr_err ? '0 : err_sticky) | fail_c;
            pass_cnt   <= sat_add(clr_err ? '0 : pass_cnt, pass_num_c);
            fail_cnt   <= sat_add(clr_err ? '0 : fail_cnt, fail_num_c);
            cfg_err    <= (eff_min_c > max_lat);
        end
    end
endmodule

// File: tb/tb_req_gnt_latency_checker.sv
// Bench for req_gnt_latency_checker: directed scenarios then random traffic, two DUT
// configurations checked every cycle against a timestamp-based reference model.
module tb_req_gnt_latency_checker;
    localparam int unsigned NCH = 4;
    localparam int unsigned LW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] enb, req, gnt;
    logic [LW-1:0]  min_lat, max_lat;
    logic           clr_err;

    logic [NCH-1:0] busy_a, pp_a, fp_a, es_a;
    logic [NCH-1:0] busy_b, pp_b, fp_b, es_b;
    logic           cfg_a, cfg_b;
    logic [15:0]    pc_a, fc_a;
    logic [1:0]     pc_b, fc_b;

    always #5 clk = ~clk;

    req_gnt_latency_checker #(.NCH(NCH), .LW(LW), .CW(16), .ABORT_ON_DIS(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enb(enb), .req(req), .gnt(gnt),
        .min_lat(min_lat), .max_lat(max_lat), .clr_err(clr_err),
        .busy(busy_a), .pass_pulse(pp_a), .fail_pulse(fp_a), .err_sticky(es_a),
        .cfg_err(cfg_a), .pass_cnt(pc_a), .fail_cnt(fc_a)
    );

    req_gnt_latency_checker #(.NCH(NCH), .LW(LW), .CW(2), .ABORT_ON_DIS(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enb(enb), .req(req), .gnt(gnt),
        .min_lat(min_lat), .max_lat(max_lat), .clr_err(clr_err),
        .busy(busy_b), .pass_pulse(pp_b), .fail_pulse(fp_b), .err_sticky(es_b),
        .cfg_err(cfg_b), .pass_cnt(pc_b), .fail_cnt(fc_b)
    );

    // Reference model: index 0 = no-abort/16-bit counters, index 1 = abort/2-bit counters.
    bit             mw  [2][NCH];
    int             mt0 [2][NCH];
    int             mmn [2][NCH];
    int             mmx [2][NCH];
    logic [NCH-1:0] e_busy [2];
    logic [NCH-1:0] e_pp   [2];
    logic [NCH-1:0] e_fp   [2];
    logic [NCH-1:0] e_es   [2];
    int             e_pc   [2];
    int             e_fc   [2];
    logic           e_cfg;
    int             cyc;
    int             npass, nfail, ntot;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) mw[m][c] = 1'b0;
            e_busy[m] = '0; e_pp[m] = '0; e_fp[m] = '0; e_es[m] = '0;
            e_pc[m] = 0; e_fc[m] = 0;
        end
        e_cfg = 1'b0;
    endtask

    task automatic model_edge();
        int el, np, nf, cap, emin;
        bit rp, rf, cfg_now;
        cfg_now = e_cfg;
        cyc++;
        emin = (min_lat == '0) ? 1 : int'(min_lat);
        for (int m = 0; m < 2; m++) begin
            cap = (m == 0) ? 65535 : 3;
            np = 0;
            nf = 0;
            if (clr_err) begin
                e_es[m] = '0; e_pc[m] = 0; e_fc[m] = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                rp = 1'b0;
                rf = 1'b0;
                if (mw[m][c]) begin
                    el = cyc - mt0[m][c];
                    if (gnt[c]) begin
                        if (el < mmn[m][c]) rf = 1'b1;
                        else                rp = 1'b1;
                    end else if (el == mmx[m][c]) begin
                        rf = 1'b1;
                    end else if (m == 1 && !enb[c]) begin
                        mw[m][c] = 1'b0;
                    end
                    if (rp || rf) mw[m][c] = 1'b0;
                end
                if (!mw[m][c] && enb[c] && req[c] && !cfg_now) begin
                    mw[m][c]  = 1'b1;
                    mt0[m][c] = cyc;
                    mmn[m][c] = emin;
                    mmx[m][c] = int'(max_lat);
                end
                e_busy[m][c] = mw[m][c];
                e_pp[m][c]   = rp;
                e_fp[m][c]   = rf;
                if (rf) e_es[m][c] = 1'b1;
                np += int'(rp);
                nf += int'(rf);
            end
            e_pc[m] = (e_pc[m] + np > cap) ? cap : e_pc[m] + np;
            e_fc[m] = (e_fc[m] + nf > cap) ? cap : e_fc[m] + nf;
        end
        e_cfg = (emin > int'(max_lat));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":busy_a"}, 32'(busy_a), 32'(e_busy[0]));
        chk({ph, ":pass_a"}, 32'(pp_a),   32'(e_pp[0]));
        chk({ph, ":fail_a"}, 32'(fp_a),   32'(e_fp[0]));
        chk({ph, ":err_a"},  32'(es_a),   32'(e_es[0]));
        chk({ph, ":cfg_a"},  32'(cfg_a),  32'(e_cfg));
        chk({ph, ":pcnt_a"}, 32'(pc_a),   32'(e_pc[0]));
        chk({ph, ":fcnt_a"}, 32'(fc_a),   32'(e_fc[0]));
        chk({ph, ":busy_b"}, 32'(busy_b), 32'(e_busy[1]));
        chk({ph, ":pass_b"}, 32'(pp_b),   32'(e_pp[1]));
        chk({ph, ":fail_b"}, 32'(fp_b),   32'(e_fp[1]));
        chk({ph, ":err_b"},  32'(es_b),   32'(e_es[1]));
        chk({ph, ":cfg_b"},  32'(cfg_b),  32'(e_cfg));
        chk({ph, ":pcnt_b"}, 32'(pc_b),   32'(e_pc[1]));
        chk({ph, ":fcnt_b"}, 32'(fc_b),   32'(e_fc[1]));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic mid_reset(input string ph);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        npass = 0; nfail = 0; ntot = 0; cyc = 0;
        rst_n = 1'b0; enb = '0; req = '0; gnt = '0; clr_err = 1'b0;
        min_lat = LW'(4); max_lat = LW'(4);
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // 1: exact window pass
        enb = '1; req = NCH'(1);
        step("t1_arm");
        req = '0;
        repeat (3) step("t1_wait");
        gnt = NCH'(1);
        step("t1_res");
        chk("t1_pass_anchor", 32'(pp_a[0]), 32'(1));
        gnt = '0;
        step("t1_idle");
        chk("t1_pcnt_anchor", 32'(pc_a), 32'(1));

        // 2: early grant fails, later grant ignored
        req = NCH'(1);
        step("t2_arm");
        req = '0;
        repeat (2) step("t2_wait");
        gnt = NCH'(1);
        step("t2_early");
        chk("t2_fail_anchor", 32'(fp_a[0]), 32'(1));
        step("t2_ignored");
        gnt = '0;
        chk("t2_err_anchor", 32'(es_a[0]), 32'(1));
        chk("t2_fcnt_anchor", 32'(fc_a), 32'(1));

        // 3: timeout, then two channels passing on the same edge
        min_lat = LW'(2); max_lat = LW'(6);
        step("t3_cfg");
        req = NCH'(1);
        step("t3_arm");
        req = '0;
        repeat (6) step("t3_timeout");
        chk("t3_fcnt_anchor", 32'(fc_a), 32'(2));
        req = NCH'(6);
        step("t3_arm2");
        req = '0;
        repeat (2) step("t3_wait2");
        gnt = NCH'(6);
        step("t3_pass2");
        gnt = '0;
        chk("t3_pcnt_anchor", 32'(pc_a), 32'(3));

        // 4: back-to-back re-arm on the resolving edge
        min_lat = LW'(4); max_lat = LW'(4);
        step("t4_cfg");
        req = NCH'(1);
        step("t4_arm");
        repeat (3) step("t4_wait");
        gnt = NCH'(1);
        step("t4_rearm");
        chk("t4_busy_anchor", 32'(busy_a[0]), 32'(1));
        req = '0; gnt = '0;
        repeat (3) step("t4_wait2");
        gnt = NCH'(1);
        step("t4_res2");
        gnt = '0;
        chk("t4_pcnt_anchor", 32'(pc_a), 32'(5));
        step("t4_idle");

        // 5: enable drop aborts only the abort-mode instance
        min_lat = LW'(2); max_lat = LW'(6);
        step("t5_cfg");
        req = NCH'(1);
        step("t5_arm");
        req = '0;
        step("t5_w1");
        enb = '0;
        step("t5_abort");
        chk("t5_busy_b_anchor", 32'(busy_b[0]), 32'(0));
        repeat (4) step("t5_drain");
        enb = '1;

        // 6: config error blocks arming, mid-check reset, counter saturation
        min_lat = LW'(5); max_lat = LW'(3);
        step("t6_cfg");
        chk("t6_cfg_anchor", 32'(cfg_a), 32'(1));
        req = '1;
        step("t6_blocked");
        min_lat = LW'(2); max_lat = LW'(6);
        step("t6_cfg_fix");
        step("t6_arm");
        req = '0;
        repeat (2) step("t6_wait");
        mid_reset("t6_rst");
        min_lat = LW'(1); max_lat = LW'(1);
        req = '1;
        step("t6_arm4");
        step("t6_fail4a");
        req = '0;
        step("t6_fail4b");
        chk("t6_fcnt_a_anchor", 32'(fc_a), 32'(8));
        chk("t6_fcnt_b_anchor", 32'(fc_b), 32'(3));
        req = NCH'(1);
        step("t6_arm_clr");
        req = '0; clr_err = 1'b1;
        step("t6_clr_vs_fail");
        clr_err = 1'b0;
        chk("t6_clr_fcnt_anchor", 32'(fc_a), 32'(1));
        chk("t6_clr_err_anchor", 32'(es_a), 32'(1));

        // Random traffic
        for (int it = 0; it < 2000; it++) begin
            enb = NCH'($urandom) | NCH'($urandom);
            req = NCH'($urandom) & NCH'($urandom);
            gnt = NCH'($urandom) & NCH'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                min_lat = LW'($urandom_range(0, 8));
                max_lat = LW'($urandom_range(0, 15));
            end
            clr_err = ($urandom_range(0, 63) == 0);
            step("rand");
            if ($urandom_range(0, 499) == 0) mid_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
